wordle_game_ctrl: RTL and testbench

Sequencing controller for the Wordle game datapath; runs on the divided system clock.
- Turns debounced single-cycle button pulses into letter entry on a 6x5 board, evaluates each submitted guess against the latched answer word, and tracks win/lose.
- Owns board storage: letters plus per-cell colour.
- Exposes an asynchronous read port for the VGA renderer, and one-hot state outputs for the LEDs.

---
 rtl/wordle_game_ctrl_pkg.sv | 37 +++
 rtl/wordle_eval_unit.sv | 79 +++++++
 rtl/wordle_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_wordle_game_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wordle_game_ctrl_pkg.sv
// Shared constants, types and letter helpers for the Wordle game controller.
package wordle_game_ctrl_pkg;

  localparam int unsigned WORD_LEN = 5;
  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned LTR_W    = 5;

  typedef logic [LTR_W-1:0] letter_t;
  typedef logic [1:0]       color_t;

  localparam color_t  CLR_EMPTY  = 2'b00;
  localparam color_t  CLR_GRAY   = 2'b01;
  localparam color_t  CLR_YELLOW = 2'b10;
  localparam color_t  CLR_GREEN  = 2'b11;

  localparam letter_t LTR_A = 5'd0;
  localparam letter_t LTR_Z = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_EVAL_G,
    ST_EVAL_Y,
    ST_CHECK,
    ST_WIN,
    ST_LOSE
  } state_t;

  function automatic letter_t ltr_inc(input letter_t l);
    return (l >= LTR_Z) ? LTR_A : letter_t'(l + 5'd1);
  endfunction

  function automatic letter_t ltr_dec(input letter_t l);
    return (l == LTR_A || l > LTR_Z) ? LTR_Z : letter_t'(l - 5'd1);
  endfunction

endpackage

// File: rtl/wordle_eval_unit.sv
// Guess evaluator: one green pass, then one yellow/gray decision per letter.
module wordle_eval_unit
  import wordle_game_ctrl_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [WORD_LEN*LTR_W-1:0] i_guess,
  input  logic [WORD_LEN*LTR_W-1:0] i_answer,
  output logic [2*WORD_LEN-1:0]     o_color,
  output logic                      o_done
);

  logic [WORD_LEN-1:0]   w_green;
  logic [WORD_LEN-1:0]   w_claim;
  logic                  w_found;
  logic                  w_cur_green;
  letter_t               w_cur;
  logic [WORD_LEN-1:0]   r_used;
  logic [2*WORD_LEN-1:0] r_color;
  logic [2:0]            r_idx;
  logic                  r_busy;

  // Exact position matches between guess and answer.
  always_comb begin
    w_green = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++)
      w_green[3'(i)] = (i_guess[i*LTR_W +: LTR_W] == i_answer[i*LTR_W +: LTR_W]);
  end

  // Lowest unused answer position holding the current guess letter.
  always_comb begin
    w_cur       = '0;
    w_cur_green = 1'b0;
    w_found     = 1'b0;
    w_claim     = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      if (32'(r_idx) == i) begin
        w_cur       = i_guess[i*LTR_W +: LTR_W];
        w_cur_green = w_green[3'(i)];
      end
    end
    for (int unsigned j = 0; j < WORD_LEN; j++) begin
      if (!w_found && !r_used[3'(j)] && (i_answer[j*LTR_W +: LTR_W] == w_cur)) begin
        w_found         = 1'b1;
        w_claim[3'(j)]  = 1'b1;
      end
    end
  end

  // Green pass on start, then walk the letters marking yellow or gray.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_used  <= '0;
      r_color <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_used <= w_green;
      r_idx  <= '0;
      r_busy <= 1'b1;
      for (int unsigned i = 0; i < WORD_LEN; i++)
        r_color[2*i +: 2] <= w_green[3'(i)] ? CLR_GREEN : CLR_EMPTY;
    end else if (r_busy) begin
      if (!w_cur_green) begin
        r_used <= r_used | w_claim;
        for (int unsigned i = 0; i < WORD_LEN; i++)
          if (32'(r_idx) == i)
            r_color[2*i +: 2] <= w_found ? CLR_YELLOW : CLR_GRAY;
      end
      if (r_idx == 3'(WORD_LEN-1)) r_busy <= 1'b0;
      else                         r_idx  <= r_idx + 3'd1;
    end
  end

  assign o_color = r_color;
  assign o_done  = r_busy && (r_idx == 3'(WORD_LEN-1));

endmodule

// File: rtl/wordle_game_ctrl.sv
// Wordle sequencing controller: letter entry, guess evaluation, board storage.
module wordle_game_ctrl
  import wordle_game_ctrl_pkg::*;
(
  input  logic                      Clk,
  input  logic                      reset,
  input  logic                      Start,
  input  logic                      Ack,
  input  logic                      U,
  input  logic                      D,
  input  logic                      L,
  input  logic                      R,
  input  logic                      C,
  input  logic [WORD_LEN*LTR_W-1:0] answer,
  input  logic [2:0]                rd_row,
  input  logic [2:0]                rd_col,
  output logic [LTR_W-1:0]          rd_letter,
  output logic [1:0]                rd_color,
  output logic [2:0]                cur_row,
  output logic [2:0]                cur_col,
  output logic                      q_I,
  output logic                      q_Entry,
  output logic                      q_Eval,
  output logic                      q_Win,
  output logic                      q_Lose,
  output logic [2:0]                guesses
);

  state_t                    r_state, w_next;
  letter_t                   r_letter [NUM_ROWS][WORD_LEN];
  color_t                    r_color  [NUM_ROWS][WORD_LEN];
  logic [WORD_LEN*LTR_W-1:0] r_answer;
  logic [2:0]                r_row, r_col, r_guesses;
  logic [WORD_LEN*LTR_W-1:0] w_guess;
  logic [2*WORD_LEN-1:0]     w_eval_color;
  logic                      w_eval_done;
  logic                      w_win;

  wordle_eval_unit u_eval (
    .i_clk    (Clk),
    .i_rst_n  (reset),
    .i_start  (r_state == ST_EVAL_G),
    .i_guess  (w_guess),
    .i_answer (r_answer),
    .o_color  (w_eval_color),
    .o_done   (w_eval_done)
  );

  // Current row letters as a packed guess; win when every colour is green.
  always_comb begin
    w_guess = '0;
    w_win   = 1'b1;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      w_guess[i*LTR_W +: LTR_W] = r_letter[r_row][3'(i)];
      if (w_eval_color[2*i +: 2] != CLR_GREEN) w_win = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (Start) w_next = ST_ENTRY;
      ST_ENTRY:  if (C) w_next = ST_EVAL_G;
      ST_EVAL_G: w_next = ST_EVAL_Y;
      ST_EVAL_Y: if (w_eval_done) w_next = ST_CHECK;
      ST_CHECK: begin
        if (w_win)                            w_next = ST_WIN;
        else if (r_row == 3'(NUM_ROWS-1))     w_next = ST_LOSE;
        else                                  w_next = ST_ENTRY;
      end
      ST_WIN, ST_LOSE: if (Ack) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Board, cursor, answer latch and guess counter.
  // Evaluator colours are registered, so the row is copied one cycle behind;
  // the copy made in CHECK carries the final colours.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_answer  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_guesses <= '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++)
        for (int unsigned j = 0; j < WORD_LEN; j++) begin
          r_letter[3'(i)][3'(j)] <= LTR_A;
          r_color[3'(i)][3'(j)]  <= CLR_EMPTY;
        end
    end else begin
      case (r_state)
        ST_IDLE: if (Start) begin
          r_answer  <= answer;
          r_row     <= '0;
          r_col     <= '0;
          r_guesses <= '0;
          for (int unsigned i = 0; i < NUM_ROWS; i++)
            for (int unsigned j = 0; j < WORD_LEN; j++) begin
              r_letter[3'(i)][3'(j)] <= LTR_A;
              r_color[3'(i)][3'(j)]  <= CLR_EMPTY;
            end
        end
        ST_ENTRY: begin
          if (C)      ;
          else if (U) r_letter[r_row][r_col] <= ltr_inc(r_letter[r_row][r_col]);
          else if (D) r_letter[r_row][r_col] <= ltr_dec(r_letter[r_row][r_col]);
          else if (R) begin
            if (r_col != 3'(WORD_LEN-1)) r_col <= r_col + 3'd1;
          end else if (L) begin
            if (r_col != 3'd0) r_col <= r_col - 3'd1;
          end
        end
        ST_EVAL_Y, ST_CHECK: begin
          for (int unsigned i = 0; i < WORD_LEN; i++)
            r_color[r_row][3'(i)] <= w_eval_color[2*i +: 2];
          if (r_state == ST_CHECK) begin
            r_guesses <= r_guesses + 3'd1;
            if (!w_win && r_row != 3'(NUM_ROWS-1)) begin
              r_row <= r_row + 3'd1;
              r_col <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Asynchronous renderer read port with out-of-range guard.
  always_comb begin
    rd_letter = LTR_A;
    rd_color  = CLR_EMPTY;
    if (rd_row < 3'(NUM_ROWS) && rd_col < 3'(WORD_LEN)) begin
      rd_letter = r_letter[rd_row][rd_col];
      rd_color  = r_color[rd_row][rd_col];
    end
  end

  assign cur_row = r_row;
  assign cur_col = r_col;
  assign guesses = r_guesses;
  assign q_I     = (r_state == ST_IDLE);
  assign q_Entry = (r_state == ST_ENTRY);
  assign q_Eval  = (r_state == ST_EVAL_G) || (r_state == ST_EVAL_Y) || (r_state == ST_CHECK);
  assign q_Win   = (r_state == ST_WIN);
  assign q_Lose  = (r_state == ST_LOSE);

endmodule

// File: tb/tb_wordle_game_ctrl.sv
// Directed testbench for wordle_game_ctrl.
module tb_wordle_game_ctrl;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0, Ack = 1'b0;
  logic        U = 1'b0, D = 1'b0, L = 1'b0, R = 1'b0, C = 1'b0;
  logic [24:0] answer = '0;
  logic [2:0]  rd_row = '0, rd_col = '0;
  logic [4:0]  rd_letter;
  logic [1:0]  rd_color;
  logic [2:0]  cur_row, cur_col, guesses;
  logic        q_I, q_Entry, q_Eval, q_Win, q_Lose;

  int n_cmp = 0;
  int n_err = 0;

  wordle_game_ctrl dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack),
    .U(U), .D(D), .L(L), .R(R), .C(C), .answer(answer),
    .rd_row(rd_row), .rd_col(rd_col), .rd_letter(rd_letter), .rd_color(rd_color),
    .cur_row(cur_row), .cur_col(cur_col),
    .q_I(q_I), .q_Entry(q_Entry), .q_Eval(q_Eval), .q_Win(q_Win), .q_Lose(q_Lose),
    .guesses(guesses)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // m = {C,U,D,R,L}; held for one rising edge.
  task automatic press(input logic [4:0] m);
    {C, U, D, R, L} = m;
    @(negedge Clk);
    {C, U, D, R, L} = '0;
  endtask

  task automatic pulse_start(input logic [24:0] ans);
    answer = ans;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic pulse_ack();
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic read_cell(input int r, input int c, output logic [4:0] l, output logic [1:0] col);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    l   = rd_letter;
    col = rd_color;
  endtask

  task automatic enter_word(input logic [24:0] w);
    logic [4:0] l;
    for (int i = 0; i < 5; i++) begin
      l = w[i*5 +: 5];
      repeat (int'(l)) press(5'b01000);
      if (i < 4) press(5'b00010);
    end
  endtask

  function automatic logic [24:0] word(input int a, b, c, d, e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  initial begin
    logic [4:0]  lt;
    logic [1:0]  cl;
    logic [24:0] w_crane, w_apple, w_pappy, w_house;
    logic [1:0]  exp_pappy [5];
    logic [1:0]  exp_bAaaa [5];

    w_crane = word(2, 17, 0, 13, 4);
    w_apple = word(0, 15, 15, 11, 4);
    w_pappy = word(15, 0, 15, 15, 24);
    w_house = word(7, 14, 20, 18, 4);
    exp_pappy = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
    exp_bAaaa = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01};

    // Reset state
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    check("rst_qI", q_I, 1);
    check("rst_row", cur_row, 0);
    check("rst_col", cur_col, 0);
    check("rst_guesses", guesses, 0);
    read_cell(0, 0, lt, cl);
    check("rst_color", cl, 0);
    check("rst_letter", lt, 0);
    @(negedge Clk);

    // Buttons ignored in IDLE
    press(5'b01000);
    read_cell(0, 0, lt, cl);
    check("idle_btn_letter", lt, 0);
    @(negedge Clk);

    // Test 1: CRANE wins in one guess with 7-cycle submit latency
    pulse_start(w_crane);
    check("t1_entry", q_Entry, 1);
    enter_word(w_crane);
    check("t1_col", cur_col, 4);
    read_cell(0, 1, lt, cl);
    check("t1_letter_r", lt, 17);
    read_cell(0, 3, lt, cl);
    check("t1_letter_n", lt, 13);
    @(negedge Clk);
    press(5'b10000);
    repeat (6) @(negedge Clk);
    check("t1_eval_at_n6", q_Eval, 1);
    @(negedge Clk);
    check("t1_win", q_Win, 1);
    check("t1_guesses", guesses, 1);
    for (int c = 0; c < 5; c++) begin
      read_cell(0, c, lt, cl);
      check($sformatf("t1_green_c%0d", c), cl, 3);
    end
    read_cell(0, 5, lt, cl);
    check("oor_col_letter", lt, 0);
    read_cell(6, 0, lt, cl);
    check("oor_row_color", cl, 0);
    @(negedge Clk);
    pulse_start(w_apple);
    check("t1_start_ignored", q_Win, 1);
    pulse_ack();
    check("t1_ack_idle", q_I, 1);
    read_cell(0, 0, lt, cl);
    check("t1_retained_letter", lt, 2);
    check("t1_retained_color", cl, 3);
    @(negedge Clk);

    // Test 2: APPLE vs PAPPY
    pulse_start(w_apple);
    read_cell(0, 0, lt, cl);
    check("t2_cleared", lt, 0);
    @(negedge Clk);
    enter_word(w_pappy);
    press(5'b10000);
    repeat (7) @(negedge Clk);
    for (int c = 0; c < 5; c++) begin
      read_cell(0, c, lt, cl);
      check($sformatf("t2_color_c%0d", c), cl, exp_pappy[c]);
    end
    check("t2_entry", q_Entry, 1);
    check("t2_row", cur_row, 1);
    check("t2_col", cur_col, 0);
    check("t2_guesses", guesses, 1);
    @(negedge Clk);

    // Test 5: U+R together increments only; C during EVAL ignored
    press(5'b01010);
    read_cell(1, 0, lt, cl);
    check("t5_letter_inc", lt, 1);
    check("t5_col_same", cur_col, 0);
    @(negedge Clk);
    press(5'b10000);
    press(5'b10000);
    repeat (6) @(negedge Clk);
    check("t5_entry_after", q_Entry, 1);
    check("t5_row", cur_row, 2);
    check("t5_guesses", guesses, 2);
    for (int c = 0; c < 5; c++) begin
      read_cell(1, c, lt, cl);
      check($sformatf("t5_color_c%0d", c), cl, exp_bAaaa[c]);
    end
    @(negedge Clk);

    // Test 4: letter wrap and column saturation
    press(5'b00001);
    check("t4_col_sat0", cur_col, 0);
    press(5'b00100);
    read_cell(2, 0, lt, cl);
    check("t4_wrap_down", lt, 25);
    @(negedge Clk);
    press(5'b01000);
    read_cell(2, 0, lt, cl);
    check("t4_wrap_up", lt, 0);
    @(negedge Clk);
    repeat (5) press(5'b00010);
    check("t4_col_sat4", cur_col, 4);
    press(5'b00100);
    read_cell(2, 4, lt, cl);
    check("t4_d_at_col4", lt, 25);
    @(negedge Clk);

    // Test 3: HOUSE, six AAAAA guesses lose
    do_reset();
    pulse_start(w_house);
    for (int g = 0; g < 6; g++) begin
      press(5'b10000);
      repeat (7) @(negedge Clk);
      if (g < 5) check($sformatf("t3_entry_g%0d", g), q_Entry, 1);
    end
    check("t3_lose", q_Lose, 1);
    check("t3_guesses", guesses, 6);
    check("t3_row", cur_row, 5);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) begin
        read_cell(r, c, lt, cl);
        check($sformatf("t3_gray_r%0dc%0d", r, c), cl, 1);
      end
    @(negedge Clk);
    pulse_ack();
    check("t3_ack_idle", q_I, 1);
    read_cell(5, 0, lt, cl);
    check("t3_row5_letter", lt, 0);
    check("t3_row5_color", cl, 1);
    @(negedge Clk);

    // Test 6: reset during EVAL_Y clears everything at once
    pulse_start(w_house);
    press(5'b10000);
    repeat (3) @(negedge Clk);
    check("t6_in_eval", q_Eval, 1);
    read_cell(0, 0, lt, cl);
    check("t6_partial_gray", cl, 1);
    reset = 1'b0;
    #1;
    check("t6_qI_async", q_I, 1);
    check("t6_qEval_off", q_Eval, 0);
    check("t6_row", cur_row, 0);
    read_cell(0, 0, lt, cl);
    check("t6_color_clear", cl, 0);
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    check("t6_stay_idle", q_I, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
